// File: rtl/ask_fsk_demod_pkg.sv
// Shared definitions for the ASK/FSK receiver: FSM encodings, mode codes and
// a width helper for the window/crossing counters.
package ask_fsk_demod_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ACQ  = 2'd1;
   localparam state_t ST_RUN  = 2'd2;

   localparam logic MODE_ASK = 1'b0;
   localparam logic MODE_FSK = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ask_fsk_demod_abs_sat.sv
// Saturating magnitude of a two's-complement sample; the most negative code
// maps to the largest positive code so the result fits in W-1 bits.
module abs_sat #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   output logic [W-2:0] mag
);

   logic [W-1:0] neg_s;

   // negate and clamp the single code that has no positive counterpart
   always_comb begin
      neg_s = {W{1'b0}} - x;
      if (x[W-1] == 1'b0) begin
         mag = x[W-2:0];
      end else if (x == {1'b1, {(W-1){1'b0}}}) begin
         mag = {(W-1){1'b1}};
      end else begin
         mag = neg_s[W-2:0];
      end
   end

endmodule

// File: rtl/ask_fsk_demod.sv
// Receive-side ASK/FSK demodulator: one bit per SPB-sample window, decided by
// windowed peak magnitude (ASK) or windowed zero-crossing count (FSK).
module ask_fsk_demod
   import ask_fsk_demod_pkg::*;
#(
   parameter int W          = 8,
   parameter int SPB        = 256,
   parameter int ZC_THRESH  = 5,
   parameter int AMP_THRESH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic         s_valid,
   input  logic [W-1:0] s_data,
   output logic         bit_out,
   output logic         bit_valid,
   output logic         locked,
   output logic         lost
);

   localparam int CW = clog2(SPB + 1);
   localparam logic [CW-1:0] SPB_C = CW'(SPB);
   localparam logic [CW-1:0] ZC_C  = CW'(ZC_THRESH);
   localparam logic [W-2:0]  AMP_C = (W-1)'(AMP_THRESH);

   state_t        state_r, state_nx_s;
   logic          prev_sign_r, prev_sign_nx_s;
   logic [CW-1:0] win_cnt_r, win_cnt_nx_s;
   logic [CW-1:0] zc_cnt_r, zc_cnt_nx_s;
   logic [W-2:0]  peak_r, peak_nx_s;
   logic          bit_out_r, bit_out_nx_s;
   logic          bit_valid_r, bit_valid_nx_s;
   logic          locked_r;
   logic          lost_r, lost_nx_s;

   logic [W-2:0]  mag_s;
   logic          sign_s;
   logic          cross_s;
   logic [CW-1:0] win_inc_s;
   logic [CW-1:0] zc_incl_s;
   logic [W-2:0]  peak_max_s;

   abs_sat #(.W(W)) u_abs_sat (
      .x   (s_data),
      .mag (mag_s)
   );

   assign sign_s     = s_data[W-1];
   assign cross_s    = (sign_s != prev_sign_r);
   assign win_inc_s  = win_cnt_r + {{(CW-1){1'b0}}, 1'b1};
   assign zc_incl_s  = (zc_cnt_r == SPB_C) ? zc_cnt_r : (zc_cnt_r + {{(CW-1){1'b0}}, cross_s});
   assign peak_max_s = (mag_s > peak_r) ? mag_s : peak_r;

   // next-state, window accumulation and decision logic
   always_comb begin
      state_nx_s     = state_r;
      prev_sign_nx_s = prev_sign_r;
      win_cnt_nx_s   = win_cnt_r;
      zc_cnt_nx_s    = zc_cnt_r;
      peak_nx_s      = peak_r;
      bit_out_nx_s   = bit_out_r;
      bit_valid_nx_s = 1'b0;
      lost_nx_s      = 1'b0;
      if (!en) begin
         state_nx_s   = ST_IDLE;
         win_cnt_nx_s = {CW{1'b0}};
         zc_cnt_nx_s  = {CW{1'b0}};
         peak_nx_s    = {(W-1){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nx_s = ST_ACQ;
            end
            ST_ACQ: begin
               if (s_valid) begin
                  prev_sign_nx_s = sign_s;
                  if (mag_s >= AMP_C) begin
                     // the acquiring sample is already sample 1 of the first window
                     state_nx_s   = ST_RUN;
                     win_cnt_nx_s = {{(CW-1){1'b0}}, 1'b1};
                     peak_nx_s    = mag_s;
                     zc_cnt_nx_s  = {CW{1'b0}};
                  end else begin
                     state_nx_s = ST_ACQ;
                  end
               end else begin
                  state_nx_s = ST_ACQ;
               end
            end
            ST_RUN: begin
               if (s_valid) begin
                  prev_sign_nx_s = sign_s;
                  if (win_inc_s == SPB_C) begin
                     win_cnt_nx_s = {CW{1'b0}};
                     zc_cnt_nx_s  = {CW{1'b0}};
                     peak_nx_s    = {(W-1){1'b0}};
                     if ((mode == MODE_FSK) && (zc_incl_s == {CW{1'b0}})) begin
                        lost_nx_s  = 1'b1;
                        state_nx_s = ST_ACQ;
                     end else if (mode == MODE_FSK) begin
                        bit_valid_nx_s = 1'b1;
                        bit_out_nx_s   = (zc_incl_s >= ZC_C);
                     end else begin
                        bit_valid_nx_s = 1'b1;
                        bit_out_nx_s   = (peak_max_s >= AMP_C);
                     end
                  end else begin
                     win_cnt_nx_s = win_inc_s;
                     zc_cnt_nx_s  = zc_incl_s;
                     peak_nx_s    = peak_max_s;
                  end
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
            default: begin
               state_nx_s   = ST_IDLE;
               win_cnt_nx_s = {CW{1'b0}};
               zc_cnt_nx_s  = {CW{1'b0}};
               peak_nx_s    = {(W-1){1'b0}};
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         prev_sign_r <= 1'b0;
         win_cnt_r   <= {CW{1'b0}};
         zc_cnt_r    <= {CW{1'b0}};
         peak_r      <= {(W-1){1'b0}};
         bit_out_r   <= 1'b0;
         bit_valid_r <= 1'b0;
         locked_r    <= 1'b0;
         lost_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         prev_sign_r <= prev_sign_nx_s;
         win_cnt_r   <= win_cnt_nx_s;
         zc_cnt_r    <= zc_cnt_nx_s;
         peak_r      <= peak_nx_s;
         bit_out_r   <= bit_out_nx_s;
         bit_valid_r <= bit_valid_nx_s;
         locked_r    <= (state_nx_s == ST_RUN);
         lost_r      <= lost_nx_s;
      end
   end

   assign bit_out   = bit_out_r;
   assign bit_valid = bit_valid_r;
   assign locked    = locked_r;
   assign lost      = lost_r;

endmodule

// File: tb/tb_ask_fsk_demod.sv
// Directed bench for ask_fsk_demod: a reference receiver model predicts every
// output per clock and queues expected bits that are popped on bit_valid.
module tb_ask_fsk_demod;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic       s_valid;
   logic [7:0] s_data;
   logic       bit_out;
   logic       bit_valid;
   logic       locked;
   logic       lost;

   ask_fsk_demod dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .locked    (locked),
      .lost      (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic exp_q[$];

   // reference model state
   int   m_st;          // 0 idle, 1 acq, 2 run
   int   m_win, m_zc, m_peak;
   logic m_prev;
   logic m_bit_out, m_valid, m_locked, m_lost;
   int   n_bits, n_lost;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_win = 0; m_zc = 0; m_peak = 0; m_prev = 1'b0;
      m_bit_out = 1'b0; m_valid = 1'b0; m_locked = 1'b0; m_lost = 1'b0;
   endtask

   task automatic model_update(input logic [7:0] d, input logic v, input logic e, input logic m);
      int a;
      logic sg;
      a = $signed(d);
      if (a < 0) a = -a;
      if (a > 127) a = 127;
      sg = d[7];
      m_valid = 1'b0;
      m_lost  = 1'b0;
      if (!e) begin
         m_st = 0; m_win = 0; m_zc = 0; m_peak = 0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (v && m_st == 1) begin
         m_prev = sg;
         if (a >= 64) begin
            m_st = 2; m_win = 1; m_peak = a; m_zc = 0;
         end
      end else if (v && m_st == 2) begin
         if (sg != m_prev && m_zc < 256) m_zc++;
         m_prev = sg;
         if (a > m_peak) m_peak = a;
         m_win++;
         if (m_win == 256) begin
            if (m && m_zc == 0) begin
               m_lost = 1'b1;
               m_st = 1;
            end else begin
               m_bit_out = m ? (m_zc >= 5) : (m_peak >= 64);
               m_valid = 1'b1;
               exp_q.push_back(m_bit_out);
            end
            m_win = 0; m_zc = 0; m_peak = 0;
         end
      end
      m_locked = (m_st == 2);
   endtask

   task automatic step(input logic [7:0] d, input logic v);
      logic e_d, m_d;
      logic exp_b;
      @(negedge clk);
      s_data  = d;
      s_valid = v;
      e_d = en;
      m_d = mode;
      @(posedge clk);
      #1;
      model_update(d, v, e_d, m_d);
      check("bit_valid", 16'(bit_valid), 16'(m_valid));
      check("locked", 16'(locked), 16'(m_locked));
      check("lost", 16'(lost), 16'(m_lost));
      check("bit_out_hold", 16'(bit_out), 16'(m_bit_out));
      if (lost === 1'b1) n_lost++;
      if (bit_valid === 1'b1) begin
         n_bits++;
         if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("scoreboard_bit", 16'(bit_out), 16'(exp_b));
         end else begin
            check("scoreboard_empty", 16'(1), 16'(0));
         end
      end
   endtask

   function automatic logic [7:0] tone_sample(input int f, input int amp, input int k);
      real r;
      int  s;
      r = amp * $sin(2.0 * 3.14159265358979 * f * (k + 32) / 256.0);
      if (r >= 0.0) s = $rtoi(r + 0.5);
      else s = -$rtoi(-r + 0.5);
      return 8'(s);
   endfunction

   task automatic tone_block(input int f, input int amp, input logic gap);
      for (int k = 0; k < 256; k++) begin
         step(tone_sample(f, amp, k), 1'b1);
         if (gap) step(8'($urandom_range(0, 255)), 1'b0);
      end
   endtask

   task automatic zero_block(input logic gap);
      for (int k = 0; k < 256; k++) begin
         step(8'h00, 1'b1);
         if (gap) step(8'($urandom_range(0, 255)), 1'b0);
      end
   endtask

   task automatic restart(input logic md);
      en = 1'b0;
      step(8'h00, 1'b0);
      mode = md;
      en = 1'b1;
      step(8'h00, 1'b0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      n_bits = 0; n_lost = 0;
      model_reset();
      #12;
      check("rst_bit_out", 16'(bit_out), 16'(0));
      check("rst_bit_valid", 16'(bit_valid), 16'(0));
      check("rst_locked", 16'(locked), 16'(0));
      check("rst_lost", 16'(lost), 16'(0));
      @(negedge clk);
      rst = 1'b1;

      // 1: reset with the window half full
      restart(1'b0);
      for (int k = 0; k < 128; k++) step(tone_sample(1, 127, k), 1'b1);
      check("t1_locked_mid", 16'(locked), 16'(1));
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check("t1_async_bit_out", 16'(bit_out), 16'(0));
      check("t1_async_bit_valid", 16'(bit_valid), 16'(0));
      check("t1_async_locked", 16'(locked), 16'(0));
      check("t1_async_lost", 16'(lost), 16'(0));
      @(negedge clk);
      rst = 1'b1;
      step(8'h00, 1'b0);
      step(8'd100, 1'b1);
      check("t1_acq_then_run", 16'(locked), 16'(1));

      // 2: ASK, leading 1 then 1,0,1,1
      exp_q.delete();
      restart(1'b0);
      n_bits = 0;
      tone_block(1, 127, 1'b0);
      tone_block(1, 127, 1'b0);
      zero_block(1'b0);
      tone_block(1, 127, 1'b0);
      tone_block(1, 127, 1'b0);
      check("t2_bit_count", 16'(n_bits), 16'(5));

      // 3: FSK, pattern 0,1,1,0
      restart(1'b1);
      n_bits = 0;
      tone_block(1, 127, 1'b0);
      tone_block(4, 127, 1'b0);
      tone_block(4, 127, 1'b0);
      tone_block(1, 127, 1'b0);
      check("t3_bit_count", 16'(n_bits), 16'(4));
      check("t3_last_bit", 16'(bit_out), 16'(0));

      // 4: FSK carrier loss on a flat window
      n_lost = 0;
      n_bits = 0;
      zero_block(1'b0);
      check("t4_lost_count", 16'(n_lost), 16'(1));
      check("t4_no_bits", 16'(n_bits), 16'(0));
      check("t4_unlocked", 16'(locked), 16'(0));

      // 5: -128 only, then en drop at win_cnt=100
      restart(1'b0);
      n_bits = 0;
      for (int k = 0; k < 356; k++) step(8'h80, 1'b1);
      check("t5_bit_count", 16'(n_bits), 16'(1));
      check("t5_bit_one", 16'(bit_out), 16'(1));
      en = 1'b0;
      step(8'h80, 1'b1);
      step(8'h80, 1'b1);
      check("t5_idle_unlocked", 16'(locked), 16'(0));
      check("t5_bit_held", 16'(bit_out), 16'(1));
      check("t5_no_extra_bit", 16'(n_bits), 16'(1));

      // 6: test 2 pattern with s_valid toggling every clock
      restart(1'b0);
      n_bits = 0;
      tone_block(1, 127, 1'b1);
      tone_block(1, 127, 1'b1);
      zero_block(1'b1);
      tone_block(1, 127, 1'b1);
      tone_block(1, 127, 1'b1);
      check("t6_bit_count", 16'(n_bits), 16'(5));
      check("t6_queue_drained", 16'(exp_q.size()), 16'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
